// File: rtl/fft_reader_pkg.sv
// Shared types and helpers for the FFT result read-out path.
package fft_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } rd_state_e;

  // Skid buffer depth; two entries cover the one-cycle read latency at full rate.
  localparam int RD_FIFO_DEPTH = 2;

  // Reverse the low 'width' bits of value (width <= 32); upper result bits are 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = value[31-i];
    end
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/fft_rd_skid_fifo.sv
// Two-entry synchronous FIFO holding {k, data} beats between memory and stream.
module fft_rd_skid_fifo
  import fft_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  // Pointers are one bit wide because the depth is fixed at two.
  logic [W-1:0] mem_q [RD_FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  // Pop only when something is held; push on full only alongside a pop.
  always_comb begin
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  end

  // Storage, pointers and occupancy; storage clears so the head reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// Streams the N FFT results out of working memory once the FFT finishes.
//
// Stream handshake: a beat transfers on a cycle where valid_o and ready_i are
// both high; valid_o never looks at ready_i, and once raised the payload
// (data_o, index_o, last_o) holds until that transfer happens.
module fft_result_reader
  import fft_reader_pkg::*;
#(
  parameter  int N_SAMPLES   = 64,
  parameter  int DATA_W      = 32,
  parameter  bit BIT_REVERSE = 1'b1,
  localparam int ADDR_W      = $clog2(N_SAMPLES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] index_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output rd_state_e         state_o
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_SAMPLES - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     k_q, k_d;
  logic                  inflight_q;
  logic [ADDR_W-1:0]     inflight_k_q;
  logic                  pop;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [2:0]            credit_used;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  // Credit: entries held plus the read in flight, less the beat leaving now.
  assign pop         = valid_o && ready_i;
  assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_en_o     = (state_q == STREAM) && (credit_used < 3'd2);
  assign rd_addr_o   = BIT_REVERSE ? ADDR_W'(bitrev(32'(k_q), ADDR_W)) : k_q;

  // Next-state and bin counter; DRAIN finishes as soon as the last beat leaves.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (rd_en_o) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and in-flight tracking; the in-flight k tags the returning data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      k_q          <= '0;
      inflight_q   <= 1'b0;
      inflight_k_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      inflight_q   <= rd_en_o;
      inflight_k_q <= k_q;
    end
  end

  fft_rd_skid_fifo #(
    .W(ADDR_W + DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .wdata_i ({inflight_k_q, rd_data_i}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign valid_o = !fifo_empty;
  assign index_o = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign data_o  = fifo_head[DATA_W-1:0];
  assign last_o  = valid_o && (index_o == K_LAST);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: an 8-bin bit-reversed instance and a 64-bin linear one.
module tb_fft_result_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   sel   = 0;

  // ---------------- instance A: N=8, bit-reversed ----------------
  logic        a_start, a_rd_en, a_valid, a_last, a_busy, a_done;
  logic [2:0]  a_rd_addr, a_index;
  logic [31:0] a_rd_data, a_data;
  fft_reader_pkg::rd_state_e a_state;
  assign a_start = start && (sel == 0);

  fft_result_reader #(.N_SAMPLES(8), .DATA_W(32), .BIT_REVERSE(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .rd_en_o(a_rd_en),
    .rd_addr_o(a_rd_addr), .rd_data_i(a_rd_data), .valid_o(a_valid),
    .ready_i(ready), .data_o(a_data), .index_o(a_index), .last_o(a_last),
    .busy_o(a_busy), .done_o(a_done), .state_o(a_state)
  );

  // ---------------- instance B: N=64, linear ----------------
  logic        b_start, b_rd_en, b_valid, b_last, b_busy, b_done;
  logic [5:0]  b_rd_addr, b_index;
  logic [31:0] b_rd_data, b_data;
  fft_reader_pkg::rd_state_e b_state;
  assign b_start = start && (sel == 1);

  fft_result_reader #(.N_SAMPLES(64), .DATA_W(32), .BIT_REVERSE(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .rd_en_o(b_rd_en),
    .rd_addr_o(b_rd_addr), .rd_data_i(b_rd_data), .valid_o(b_valid),
    .ready_i(ready), .data_o(b_data), .index_o(b_index), .last_o(b_last),
    .busy_o(b_busy), .done_o(b_done), .state_o(b_state)
  );

  // Memories: synchronous read, garbage on cycles without a read strobe.
  logic [31:0] mem_a [8];
  logic [31:0] mem_b [64];
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : $urandom;
    b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : $urandom;
  end

  // Selected instance seen through one set of wide signals.
  logic        m_rd_en, m_valid, m_last, m_busy, m_done;
  logic [5:0]  m_addr, m_index;
  logic [31:0] m_data;
  always_comb begin
    if (sel == 0) begin
      m_rd_en = a_rd_en; m_valid = a_valid; m_last = a_last; m_busy = a_busy; m_done = a_done;
      m_addr = {3'b000, a_rd_addr}; m_index = {3'b000, a_index}; m_data = a_data;
    end else begin
      m_rd_en = b_rd_en; m_valid = b_valid; m_last = b_last; m_busy = b_busy; m_done = b_done;
      m_addr = b_rd_addr; m_index = b_index; m_data = b_data;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int tb_rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Model state: expected read addresses and beats ({k, data}) of the frame.
  logic [5:0]  exp_addr_q[$];
  logic [37:0] exp_q[$];
  int phase = 0;           // 0 idle, 1 frame running, 2 done pulse this cycle
  int reads_done = 0;      // reads issued before the current cycle
  int reads_lag  = 0;      // reads issued at least two cycles ago (data landed)
  int acc        = 0;      // beats accepted before the current cycle
  int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = -1;
  int n_rd_act = 0, n_beat_act = 0;
  int rd_log_cyc[64], rd_log_addr[64], beat_cyc[64];
  logic [31:0] beat_data[64];
  bit armed = 0, rst_prev = 0;

  // One compare per cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    int ph0, rel, n_cur, aw, addr;
    bit exp_rd, exp_valid, pop_m;
    logic [37:0] b;
    cyc++;
    n_cur = (sel == 0) ? 8 : 64;
    aw    = (sel == 0) ? 3 : 6;
    if (!armed) begin
      if (rst_n === 1'b0) begin armed = 1; rst_prev = 1; end
    end else begin
      ph0 = phase;
      rel = cyc - start_cyc;
      exp_valid = (reads_lag > acc);
      pop_m = exp_valid && ready;
      chk("busy_o", m_busy, ph0 != 0);
      chk("done_o", m_done, ph0 == 2);
      if (rst_prev) begin
        chk("rst_rd_addr", m_addr, 0);
        chk("rst_data", m_data, 0);
        chk("rst_index", m_index, 0);
      end
      if (m_done === 1'b1) begin done_cnt++; done_cyc = rel; end
      exp_rd = (ph0 == 1) && (exp_addr_q.size() > 0) && ((reads_done - acc - (pop_m ? 1 : 0)) < 2);
      chk("rd_en_o", m_rd_en, exp_rd);
      if (m_rd_en === 1'b1 && n_rd_act < 64) begin
        rd_log_cyc[n_rd_act] = rel; rd_log_addr[n_rd_act] = int'(m_addr); n_rd_act++;
      end
      if (exp_rd) chk("rd_addr_o", m_addr, exp_addr_q.pop_front());
      chk("valid_o", m_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
        b = exp_q[0];
        chk("index_o", m_index, b[37:32]);
        chk("data_o", m_data, b[31:0]);
        chk("last_o", m_last, int'(b[37:32]) == n_cur - 1);
        if (ready) begin
          if (n_beat_act < 64) begin
            beat_cyc[n_beat_act] = rel; beat_data[n_beat_act] = m_data; n_beat_act++;
          end
          void'(exp_q.pop_front());
          acc++;
          if (exp_q.size() == 0) phase = 2;
        end
      end else begin
        chk("last_idle", m_last, 0);
      end
      reads_lag = reads_done;
      if (exp_rd) reads_done++;
      if (ph0 == 2) phase = 0;
      if (rst_n === 1'b1 && start === 1'b1 && ph0 == 0) begin
        exp_addr_q.delete(); exp_q.delete();
        for (int k = 0; k < n_cur; k++) begin
          addr = (sel == 0) ? tb_rev(k, aw) : k;
          exp_addr_q.push_back(6'(addr));
          exp_q.push_back({6'(k), (sel == 0) ? mem_a[addr] : mem_b[addr]});
        end
        reads_done = 0; reads_lag = 0; acc = 0;
        n_rd_act = 0; n_beat_act = 0; done_cyc = -1;
        start_cyc = cyc; phase = 1;
      end
      if (rst_n !== 1'b1) begin
        phase = 0; exp_addr_q.delete(); exp_q.delete();
        reads_done = 0; reads_lag = 0; acc = 0;
        rst_prev = 1;
      end else begin
        rst_prev = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      start = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; ready = 1'b1;
  endtask

  // mode 0: ready high; 1: ready low in cycles 4..9; 2: ready random 50%.
  task automatic run_frame(input int mode, input int start2_at, input int rst_at, input int max_c);
    int c = 0;
    int lim;
    bit fin = 0;
    lim = (start2_at > rst_at) ? start2_at : rst_at;
    if (lim < 0) lim = 0;
    while (!fin) begin
      @(posedge clk); #1;
      if (c > lim && phase == 0) begin
        start = 1'b0; rst_n = 1'b1; ready = 1'b1; fin = 1;
      end else if (c >= max_c) begin
        checks++; errors++;
        $display("FAIL frame_timeout actual=%0d cycles expected=frame end", c);
        start = 1'b0; rst_n = 1'b1; ready = 1'b1; fin = 1;
      end else begin
        start = (c == 0) || (c == start2_at);
        rst_n = (c != rst_at);
        case (mode)
          0:       ready = 1'b1;
          1:       ready = !(c >= 4 && c <= 9);
          default: ready = 1'($urandom_range(0, 1));
        endcase
        c++;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lit_addr[8];
    lit_addr = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++) mem_a[i] = i;
    for (int i = 0; i < 64; i++) mem_b[i] = $urandom;

    sel = 0;
    do_reset(4);

    // Basic frame, ready always high.
    done_cnt = 0;
    run_frame(0, -1, -1, 300);
    for (int i = 0; i < 8; i++) chk("lit_rd_addr", rd_log_addr[i], lit_addr[i]);
    chk("lit_first_rd_cyc", rd_log_cyc[0], 1);
    chk("lit_last_rd_cyc", rd_log_cyc[7], 8);
    chk("lit_first_beat_cyc", beat_cyc[0], 3);
    chk("lit_last_beat_cyc", beat_cyc[7], 10);
    chk("lit_done_cyc", done_cyc, 11);
    chk("lit_beat1_data", beat_data[1], 4);
    chk("lit_beat6_data", beat_data[6], 3);
    chk("lit_beats", n_beat_act, 8);
    chk("lit_done_cnt", done_cnt, 1);

    // Backpressure in cycles 4..9.
    done_cnt = 0;
    run_frame(1, -1, -1, 300);
    chk("bp_beats", n_beat_act, 8);
    chk("bp_done_cnt", done_cnt, 1);

    // Start pulse mid-frame is ignored.
    done_cnt = 0;
    run_frame(0, 5, -1, 300);
    chk("ign_beats", n_beat_act, 8);
    chk("ign_done_cnt", done_cnt, 1);

    // Start in the IDLE cycle right after DONE launches a second frame.
    done_cnt = 0;
    run_frame(0, 12, -1, 300);
    chk("dbl_done_cnt", done_cnt, 2);

    // Reset mid-frame, then a clean frame.
    done_cnt = 0;
    run_frame(0, -1, 6, 300);
    chk("midrst_done_cnt", done_cnt, 0);
    run_frame(0, -1, -1, 300);
    chk("after_rst_beats", n_beat_act, 8);
    chk("after_rst_done_cnt", done_cnt, 1);

    // 64-bin linear instance with random backpressure.
    sel = 1;
    do_reset(3);
    for (int f = 0; f < 3; f++) begin
      done_cnt = 0;
      run_frame(2, -1, -1, 1000);
      chk("rnd_beats", n_beat_act, 64);
      chk("rnd_done_cnt", done_cnt, 1);
    end
    run_frame(2, -1, int'($urandom_range(10, 60)), 1000);
    done_cnt = 0;
    run_frame(2, -1, -1, 1000);
    chk("rnd_after_rst_beats", n_beat_act, 64);
    chk("rnd_after_rst_done_cnt", done_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
